mmio_ctrl: RTL and testbench

MMIO_CTRL -- requirements
Module: mmio_ctrl

---
 rtl/mmio_ctrl_pkg.sv | 19 +
 rtl/mmio_ctrl_debounce.sv | 52 +++++
 rtl/mmio_ctrl.sv | 115 +++++++++++
 tb/tb_mmio_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the memory-mapped board I/O block: register map,
// debounce defaults and the KCTRL status word layout.
package mmio_ctrl_pkg;

  localparam logic [31:0] DEF_ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] DEF_ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] DEF_ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] DEF_ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] DEF_ADDR_KCTRL = 32'hF000_0110;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd1000;
  localparam int          DEB_CNT_W           = 16;

  // bit 0 summarises "any key pending" so software can poll a single bit
  function automatic logic [31:0] kctrl_word(input logic [3:0] kpend);
    return {27'b0, kpend, |kpend};
  endfunction

endpackage

// File: rtl/mmio_ctrl_debounce.sv
// One-bit input conditioner: two-flop synchronizer, stability counter and
// accepted-value flop. RST_VAL sets the idle level of the whole chain.
module mmio_ctrl_debounce #(
  parameter int                 CNT_W   = 16,
  parameter logic [CNT_W-1:0]   THRESH  = 1000,
  parameter logic               RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic acc_o
);

  localparam logic [CNT_W-1:0] TC  = THRESH - CNT_W'(1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // counter measures how long the synchronized level has disagreed with the
  // accepted level; any return to the accepted level restarts the window
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == TC) begin
      acc_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      acc_q   <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped board I/O: HEX/LEDR output registers, debounced KEY/SW
// inputs and a sticky key-press latch with write-one-to-clear.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [31:0] ADDR_HEX        = DEF_ADDR_HEX,
  parameter logic [31:0] ADDR_LEDR       = DEF_ADDR_LEDR,
  parameter logic [31:0] ADDR_KEY        = DEF_ADDR_KEY,
  parameter logic [31:0] ADDR_SW         = DEF_ADDR_SW,
  parameter logic [31:0] ADDR_KCTRL      = DEF_ADDR_KCTRL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        is_io,
  input  logic [3:0]  key_in,
  input  logic [9:0]  sw_in,
  output logic [15:0] hex_out,
  output logic [9:0]  ledr_out
);

  logic [3:0]  key_acc;
  logic [9:0]  sw_acc;
  logic [3:0]  pressed, pressed_prev_q, key_rise;
  logic [3:0]  kpend_q, kpend_d;
  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic        sel_hex, sel_ledr, sel_key, sel_sw, sel_kctrl;
  logic [31:0] rd_mux;
  logic        unused_wr_bits;

  // keys idle high (active-low buttons), switches idle low
  for (genvar i = 0; i < 4; i++) begin : g_key
    mmio_ctrl_debounce #(
      .CNT_W  (DEB_CNT_W),
      .THRESH (DEBOUNCE_CYCLES),
      .RST_VAL(1'b1)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw_i(key_in[i]),
      .acc_o(key_acc[i])
    );
  end

  for (genvar i = 0; i < 10; i++) begin : g_sw
    mmio_ctrl_debounce #(
      .CNT_W  (DEB_CNT_W),
      .THRESH (DEBOUNCE_CYCLES),
      .RST_VAL(1'b0)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw_i(sw_in[i]),
      .acc_o(sw_acc[i])
    );
  end

  always_comb begin
    sel_hex   = (addr == ADDR_HEX);
    sel_ledr  = (addr == ADDR_LEDR);
    sel_key   = (addr == ADDR_KEY);
    sel_sw    = (addr == ADDR_SW);
    sel_kctrl = (addr == ADDR_KCTRL);
    is_io     = sel_hex | sel_ledr | sel_key | sel_sw | sel_kctrl;
  end

  assign pressed  = ~key_acc;
  assign key_rise = pressed & ~pressed_prev_q;

  // clear is applied before set so a fresh press survives a concurrent W1C
  always_comb begin
    hex_d   = hex_q;
    ledr_d  = ledr_q;
    kpend_d = kpend_q;
    if (wr_en && sel_hex)   hex_d   = wr_data[15:0];
    if (wr_en && sel_ledr)  ledr_d  = wr_data[9:0];
    if (wr_en && sel_kctrl) kpend_d = kpend_d & ~wr_data[4:1];
    kpend_d = kpend_d | key_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q          <= '0;
      ledr_q         <= '0;
      kpend_q        <= '0;
      pressed_prev_q <= '0;
    end else begin
      hex_q          <= hex_d;
      ledr_q         <= ledr_d;
      kpend_q        <= kpend_d;
      pressed_prev_q <= pressed;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_hex)   rd_mux = {16'b0, hex_q};
    if (sel_ledr)  rd_mux = {22'b0, ledr_q};
    if (sel_key)   rd_mux = {28'b0, pressed};
    if (sel_sw)    rd_mux = {22'b0, sw_acc};
    if (sel_kctrl) rd_mux = kctrl_word(kpend_q);
    rd_data = rd_en ? rd_mux : 32'h0;
  end

  assign hex_out        = hex_q;
  assign ledr_out       = ledr_q;
  assign unused_wr_bits = ^wr_data[31:16];

endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl with a short debounce threshold (4):
// reads queue their expected response, a negedge monitor checks them.
module tb_mmio_ctrl;

  localparam logic [31:0] A_HEX   = 32'hF000_0000;
  localparam logic [31:0] A_LEDR  = 32'hF000_0004;
  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en, rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        is_io;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;

  typedef struct {
    logic [31:0] rd;
    logic        io;
    logic [15:0] hex;
    logic [9:0]  ledr;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] m_hex  = 16'h0;
  logic [9:0]  m_ledr = 10'h0;

  mmio_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .is_io   (is_io),
    .key_in  (key_in),
    .sw_in   (sw_in),
    .hex_out (hex_out),
    .ledr_out(ledr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_underflow actual=read expected=queued entry");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".rd_data"}, rd_data, mon_e.rd);
        chk({mon_e.name, ".is_io"}, {31'b0, is_io}, {31'b0, mon_e.io});
        chk({mon_e.name, ".hex_out"}, {16'b0, hex_out}, {16'b0, mon_e.hex});
        chk({mon_e.name, ".ledr_out"}, {22'b0, ledr_out}, {22'b0, mon_e.ledr});
      end
    end
  end

  task automatic push_exp(input logic [31:0] exp, input logic io, input string nm);
    exp_t e;
    e.rd = exp; e.io = io; e.hex = m_hex; e.ledr = m_ledr; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic io,
                    input string nm);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    push_exp(exp, io, nm);
    @(posedge clk); #1;
    rd_en = 1'b0; addr = 32'h0;
  endtask

  // also_rd: read the same address in the write cycle; data is pre-write
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic also_rd,
                    input logic [31:0] exp, input string nm);
    addr = a; wr_data = d; wr_en = 1'b1; rd_en = also_rd;
    if (also_rd) push_exp(exp, 1'b1, nm);
    if (a == A_HEX)  m_hex  = d[15:0];
    if (a == A_LEDR) m_ledr = d[9:0];
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; addr = 32'h0; wr_data = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; addr = 32'h0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 32'h0;
    key_in = 4'hF; sw_in = 10'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.hex_out", {16'b0, hex_out}, 32'h0);
    chk("reset.ledr_out", {22'b0, ledr_out}, 32'h0);
    chk("reset.is_io_unmapped", {31'b0, is_io}, 32'h0);
    reset = 1'b1;
    idle(1);

    rd(A_KEY,   32'h0, 1'b1, "post_reset_key");
    rd(A_SW,    32'h0, 1'b1, "post_reset_sw");
    rd(A_KCTRL, 32'h0, 1'b1, "post_reset_kctrl");
    rd(A_HEX,   32'h0, 1'b1, "post_reset_hex");
    rd(A_LEDR,  32'h0, 1'b1, "post_reset_ledr");

    wr(A_HEX, 32'h0000_ABCD, 1'b0, 32'h0, "");
    rd(A_HEX, 32'h0000_ABCD, 1'b1, "hex_abcd");
    wr(A_HEX, 32'hFFFF_1234, 1'b0, 32'h0, "");
    rd(A_HEX, 32'h0000_1234, 1'b1, "hex_upper_ignored");
    wr(A_LEDR, 32'hFFFF_FFFF, 1'b0, 32'h0, "");
    rd(A_LEDR, 32'h0000_03FF, 1'b1, "ledr_all");
    wr(A_LEDR, 32'h0000_0155, 1'b1, 32'h0000_03FF, "wr_rd_prewrite");
    rd(A_LEDR, 32'h0000_0155, 1'b1, "ledr_after_wr_rd");

    addr = A_HEX; rd_en = 1'b0;
    #1;
    chk("rd_en_low.rd_data", rd_data, 32'h0);
    chk("rd_en_low.is_io", {31'b0, is_io}, 32'h1);
    addr = 32'h0;

    rd(32'hF000_0008, 32'h0, 1'b0, "unmapped_08");
    rd(32'hF000_0005, 32'h0, 1'b0, "unmapped_05");
    rd(32'h7000_0000, 32'h0, 1'b0, "no_alias_hex");
    wr(32'hF000_0008, 32'hFFFF_FFFF, 1'b0, 32'h0, "");
    wr(A_KEY, 32'hFFFF_FFFF, 1'b0, 32'h0, "");
    wr(A_SW,  32'hFFFF_FFFF, 1'b0, 32'h0, "");
    rd(A_HEX,   32'h0000_1234, 1'b1, "hex_after_unmapped_wr");
    rd(A_LEDR,  32'h0000_0155, 1'b1, "ledr_after_unmapped_wr");
    rd(A_KCTRL, 32'h0, 1'b1, "kctrl_after_unmapped_wr");

    // key[2] press: accepted on the 6th edge, kpend on the 7th
    key_in = 4'b1011;
    idle(5);
    rd(A_KEY,   32'h0, 1'b1, "key2_edge5");
    rd(A_KEY,   32'h4, 1'b1, "key2_edge6");
    rd(A_KCTRL, 32'h9, 1'b1, "key2_kctrl");
    key_in = 4'hF;
    idle(8);
    rd(A_KEY,   32'h0, 1'b1, "key2_released");
    rd(A_KCTRL, 32'h9, 1'b1, "key2_kpend_sticky");

    for (int i = 0; i < 10; i++) begin
      sw_in[0] = ~sw_in[0];
      idle(2);
    end
    rd(A_SW, 32'h0, 1'b1, "sw_bounce");
    sw_in = 10'h2A5;
    idle(5);
    rd(A_SW, 32'h0,   1'b1, "sw_edge5");
    rd(A_SW, 32'h2A5, 1'b1, "sw_edge6");

    wr(A_KCTRL, 32'h1E, 1'b0, 32'h0, "");
    rd(A_KCTRL, 32'h0, 1'b1, "kctrl_clear_all");
    key_in = 4'b1100;
    idle(7);
    rd(A_KEY, 32'h3, 1'b1, "keys01_pressed");
    key_in = 4'hF;
    idle(7);
    rd(A_KEY,   32'h0, 1'b1, "keys01_released");
    rd(A_KCTRL, 32'h7, 1'b1, "kpend_0011");
    wr(A_KCTRL, 32'h2, 1'b0, 32'h0, "");
    rd(A_KCTRL, 32'h5, 1'b1, "w1c_bit0");

    // key[1] edge lands on the same clock as a W1C of kpend[1]
    key_in = 4'b1101;
    idle(6);
    wr(A_KCTRL, 32'h4, 1'b0, 32'h0, "");
    rd(A_KCTRL, 32'h5, 1'b1, "set_wins");
    key_in = 4'hF;
    idle(7);
    wr(A_KCTRL, 32'h4, 1'b0, 32'h0, "");
    rd(A_KCTRL, 32'h0, 1'b1, "w1c_bit1");

    key_in = 4'b1110;
    idle(3);
    reset = 1'b0;
    m_hex = 16'h0; m_ledr = 10'h0;
    rd(A_HEX,   32'h0, 1'b1, "in_reset_hex");
    rd(A_LEDR,  32'h0, 1'b1, "in_reset_ledr");
    rd(A_KCTRL, 32'h0, 1'b1, "in_reset_kctrl");
    rd(A_KEY,   32'h0, 1'b1, "in_reset_key");
    reset = 1'b1;
    idle(5);
    rd(A_KEY,   32'h0,   1'b1, "rel_key0_edge5");
    rd(A_KEY,   32'h1,   1'b1, "rel_key0_edge6");
    rd(A_KCTRL, 32'h3,   1'b1, "rel_key0_kpend");
    rd(A_SW,    32'h2A5, 1'b1, "rel_sw");
    idle(2);
    chk("sb_drained", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
